// File: rtl/div_ctrl_pkg.sv
// Shared types and handshake constants for the EX-stage divider sequencer.
package div_ctrl_pkg;

  localparam int unsigned RegBusW = 16;

  localparam logic RstEnable         = 1'b1;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// EX <-> divider handshake bundle; master is the EX stage, slave is div_ctrl.
interface div_ctrl_if #(
  parameter int unsigned Width = 16
);
  logic               signed_div_i;
  logic [Width-1:0]   opdata1_i;
  logic [Width-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*Width-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on the {partial remainder, dividend/quotient} work register.
module div_step #(
  parameter int unsigned Width = 16
) (
  input  logic [2*Width:0]  work_i,
  input  logic [Width-1:0]  divisor_i,
  output logic [2*Width:0]  work_o
);

  logic [2*Width:0] shifted;
  logic [Width:0]   diff;
  logic             unused_msb;

  // The partial remainder stays below the divisor, so the top bit is always shifted out as 0.
  assign unused_msb = work_i[2*Width];

  always_comb begin
    shifted = {work_i[2*Width-1:0], 1'b0};
    diff    = shifted[2*Width:Width] - {1'b0, divisor_i};
    if (shifted[2*Width:Width] >= {1'b0, divisor_i}) begin
      work_o = {diff, shifted[Width-1:1], 1'b1};
    end else begin
      work_o = shifted;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Divider sequencer: FSM, step counter, sign fix-up and registered result/ready.
// Optional DIV_EARLY_OUT_EN finishes in one extra edge when |dividend| < |divisor|.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned Width = RegBusW
) (
  input logic     clk,
  input logic     rst,
  div_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(Width + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Width);

  div_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*Width:0]   work_q, work_d, work_step;
  logic [Width-1:0]   divisor_q, divisor_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*Width-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [Width-1:0]   dd, dv, abs_dd, abs_dv, quo, rem;
  logic               abort;

  div_step #(
    .Width(Width)
  ) u_step (
    .work_i   (work_q),
    .divisor_i(divisor_q),
    .work_o   (work_step)
  );

  always_comb begin
    dd     = bus.opdata1_i;
    dv     = bus.opdata2_i;
    abs_dd = (bus.signed_div_i && dd[Width-1]) ? (~dd + 1'b1) : dd;
    abs_dv = (bus.signed_div_i && dv[Width-1]) ? (~dv + 1'b1) : dv;
    quo    = neg_quo_q ? (~work_q[Width-1:0] + 1'b1) : work_q[Width-1:0];
    rem    = neg_rem_q ? (~work_q[2*Width-1:Width] + 1'b1) : work_q[2*Width-1:Width];
    abort  = bus.annul_i || (bus.start_i == DivStop);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          if (dv == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            work_d    = {{(Width + 1){1'b0}}, abs_dd};
            divisor_d = abs_dv;
            neg_quo_d = bus.signed_div_i && (dd[Width-1] ^ dv[Width-1]);
            neg_rem_d = bus.signed_div_i && dd[Width-1];
`ifdef DIV_EARLY_OUT_EN
            // Preload a finished work reg (q=0, r=|dd|) so the next edge only runs sign fix-up.
            if (abs_dd < abs_dv) begin
              work_d = {1'b0, abs_dd, {Width{1'b0}}};
              cnt_d  = CntLast;
            end
`endif
          end
        end
      end
      DivByZero: begin
        result_d = '0;
        if (abort) begin
          state_d = DivFree;
          ready_d = DivResultNotReady;
        end else begin
          state_d = DivEnd;
          ready_d = DivResultReady;
        end
      end
      DivOn: begin
        if (abort) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q == CntLast) begin
          state_d  = DivEnd;
          result_d = {rem, quo};
          ready_d  = DivResultReady;
        end else begin
          work_d = work_step;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DivEnd: begin
        if (abort) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
